// File: rtl/riscv_ctrl_pkg.sv
// Shared control constants for the multi-cycle RV32I-subset core.
package riscv_ctrl_pkg;

  localparam int unsigned OP_W    = 7;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned CAUSE_W = 2;

  localparam logic [OP_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_REG    = 7'b0110011;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_IMEM_TO = 2'b10,
    CAUSE_DMEM_TO = 2'b11
  } cause_e;

  // True for every opcode the core implements.
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    logic legal;
    case (op)
      OP_IMM, OP_LOAD, OP_JALR, OP_STORE,
      OP_REG, OP_LUI, OP_BRANCH, OP_JAL: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Instruction/data memory request-acknowledge handshake.
interface multicycle_sequencer_if;
  logic IMEM_REQ;
  logic IMEM_ACK;
  logic DMEM_REQ;
  logic DMEM_WE;
  logic DMEM_ACK;

  modport master (output IMEM_REQ, DMEM_REQ, DMEM_WE, input IMEM_ACK, DMEM_ACK);
  modport slave  (input IMEM_REQ, DMEM_REQ, DMEM_WE, output IMEM_ACK, DMEM_ACK);
endinterface

// File: rtl/bus_wait_timer.sv
// Counts wait cycles of a pending memory request; expired marks the last acceptable cycle.
module bus_wait_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Zero disables the timeout entirely.
  assign expired = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  // Restart on state change, otherwise advance once per unacknowledged cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// FETCH/DECODE/EXEC/MEM/WB control sequencer with trap handling and retire counter.
module multicycle_sequencer
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [OP_W-1:0]          OP_CODE,
  multicycle_sequencer_if.master   bus,
  output logic                     IR_WE,
  output logic                     RF_WE,
  output logic                     PC_WE,
  output logic                     TRAP,
  output logic [CAUSE_W-1:0]       TRAP_CAUSE,
  output logic [CNT_W-1:0]         INSTRET,
  output logic [STATE_W-1:0]       STATE
);

  state_e             state_q, state_d;
  cause_e             cause_q, cause_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic               tmr_clear, tmr_tick, tmr_expired;
  logic               is_store;

  assign is_store = (OP_CODE == OP_STORE);

  // One timer serves both FETCH and MEM waits; any state change restarts it.
  assign tmr_clear = (state_d != state_q);
  assign tmr_tick  = ((state_q == ST_FETCH) && !bus.IMEM_ACK) ||
                     ((state_q == ST_MEM)   && !bus.DMEM_ACK);

  bus_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (CLK),
    .rst     (RST),
    .clear   (tmr_clear),
    .tick    (tmr_tick),
    .expired (tmr_expired)
  );

  // State, trap cause and retire counter registers; reset overrides everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_FETCH;
      cause_q   <= CAUSE_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  // Next-state and trap cause; an ack in the expiry cycle beats the timeout.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_FETCH: begin
        if (bus.IMEM_ACK) begin
          state_d = ST_DECODE;
        end else if (tmr_expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_IMEM_TO;
        end
      end
      ST_DECODE: begin
        if (is_legal_op(OP_CODE)) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      ST_EXEC: begin
        state_d = ((OP_CODE == OP_LOAD) || is_store) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        if (bus.DMEM_ACK) begin
          state_d = is_store ? ST_FETCH : ST_WB;
        end else if (tmr_expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_DMEM_TO;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  // Strobes: requests are Moore, IR/PC commits also qualify on the ack and never fire under reset.
  always_comb begin
    bus.IMEM_REQ = (state_q == ST_FETCH);
    bus.DMEM_REQ = (state_q == ST_MEM);
    bus.DMEM_WE  = (state_q == ST_MEM) && is_store;
    RF_WE        = (state_q == ST_WB) && (OP_CODE != OP_BRANCH);
    TRAP         = (state_q == ST_TRAP);
    IR_WE        = !RST && (state_q == ST_FETCH) && bus.IMEM_ACK;
    PC_WE        = !RST && ((state_q == ST_WB) ||
                            ((state_q == ST_MEM) && is_store && bus.DMEM_ACK));
    instret_d    = PC_WE ? (instret_q + CNT_W'(1)) : instret_q;
  end

  assign STATE      = state_q;
  assign TRAP_CAUSE = cause_q;
  assign INSTRET    = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer (TIMEOUT=4, CNT_W=4).
module tb_multicycle_sequencer;
  import riscv_ctrl_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [6:0] op  = 7'd0;
  logic       ir_we, rf_we, pc_we, trap;
  logic [1:0] cause;
  logic [3:0] instret;
  logic [2:0] state;
  int         total = 0;
  int         bad   = 0;

  multicycle_sequencer_if bus();

  multicycle_sequencer #(.TIMEOUT(4), .CNT_W(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .OP_CODE    (op),
    .bus        (bus),
    .IR_WE      (ir_we),
    .RF_WE      (rf_we),
    .PC_WE      (pc_we),
    .TRAP       (trap),
    .TRAP_CAUSE (cause),
    .INSTRET    (instret),
    .STATE      (state)
  );

  always #5 CLK = ~CLK;

  // {IMEM_REQ, IR_WE, DMEM_REQ, DMEM_WE, RF_WE, PC_WE}
  logic [5:0] sb;
  assign sb = {bus.IMEM_REQ, ir_we, bus.DMEM_REQ, bus.DMEM_WE, rf_we, pc_we};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply acks for the current cycle, check state/strobes, advance one clock.
  task automatic step(input logic ia, input logic da, input string tag,
                      input logic [2:0] st, input logic [5:0] s);
    bus.IMEM_ACK = ia;
    bus.DMEM_ACK = da;
    #1;
    chk({tag, ".st"}, 32'(state), 32'(st));
    chk({tag, ".sb"}, 32'(sb), 32'(s));
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST          = 1'b1;
    bus.IMEM_ACK = 1'b0;
    bus.DMEM_ACK = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  // Zero-wait non-memory instruction: F, D, E, W.
  task automatic run4(input logic [6:0] o, input string tag, input logic rf);
    op = o;
    step(1'b1, 1'b0, {tag, ".F"}, 3'd0, 6'b110000);
    step(1'b0, 1'b0, {tag, ".D"}, 3'd1, 6'b000000);
    step(1'b0, 1'b0, {tag, ".E"}, 3'd2, 6'b000000);
    step(1'b0, 1'b0, {tag, ".W"}, 3'd4, rf ? 6'b000011 : 6'b000001);
  endtask

  initial begin
    bus.IMEM_ACK = 1'b0;
    bus.DMEM_ACK = 1'b0;
    @(posedge CLK);
    #1;

    // Reset values and ADDI
    do_reset();
    #1;
    chk("rst.st", 32'(state), 32'd0);
    chk("rst.sb", 32'(sb), 32'(6'b100000));
    chk("rst.trap", 32'(trap), 32'd0);
    chk("rst.cause", 32'(cause), 32'd0);
    chk("rst.instret", 32'(instret), 32'd0);
    run4(OP_IMM, "addi", 1'b1);
    chk("addi.instret", 32'(instret), 32'd1);
    chk("addi.back", 32'(state), 32'd0);

    // LW with DMEM_ACK after 3 wait cycles: 8 cycles total
    op = OP_LOAD;
    step(1'b1, 1'b0, "lw.F", 3'd0, 6'b110000);
    step(1'b0, 1'b0, "lw.D", 3'd1, 6'b000000);
    step(1'b0, 1'b0, "lw.E", 3'd2, 6'b000000);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "lw.Mw", 3'd3, 6'b001000);
    step(1'b0, 1'b1, "lw.Mack", 3'd3, 6'b001000);
    step(1'b0, 1'b0, "lw.W", 3'd4, 6'b000011);
    chk("lw.instret", 32'(instret), 32'd2);
    chk("lw.back", 32'(state), 32'd0);

    // SW then BNE from reset
    do_reset();
    op = OP_STORE;
    step(1'b1, 1'b0, "sw.F", 3'd0, 6'b110000);
    step(1'b0, 1'b0, "sw.D", 3'd1, 6'b000000);
    step(1'b0, 1'b0, "sw.E", 3'd2, 6'b000000);
    step(1'b0, 1'b1, "sw.M", 3'd3, 6'b001101);
    chk("sw.instret", 32'(instret), 32'd1);
    run4(OP_BRANCH, "bne", 1'b0);
    chk("bne.instret", 32'(instret), 32'd2);

    // Remaining writeback opcodes
    run4(OP_REG,  "reg",  1'b1);
    run4(OP_LUI,  "lui",  1'b1);
    run4(OP_JAL,  "jal",  1'b1);
    run4(OP_JALR, "jalr", 1'b1);
    chk("mix.instret", 32'(instret), 32'd6);

    // Illegal opcode traps and holds until reset
    do_reset();
    op = 7'b0001111;
    step(1'b1, 1'b0, "ill.F", 3'd0, 6'b110000);
    step(1'b0, 1'b0, "ill.D", 3'd1, 6'b000000);
    for (int i = 0; i < 10; i++) begin
      chk("ill.trap", 32'(trap), 32'd1);
      chk("ill.cause", 32'(cause), 32'd1);
      step(1'b1, 1'b1, "ill.hold", 3'd7, 6'b000000);
    end
    chk("ill.instret", 32'(instret), 32'd0);
    do_reset();
    #1;
    chk("ill.rst.st", 32'(state), 32'd0);
    chk("ill.rst.trap", 32'(trap), 32'd0);
    chk("ill.rst.cause", 32'(cause), 32'd0);

    // IMEM timeout after 4 FETCH cycles
    do_reset();
    op = OP_IMM;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "ito.F", 3'd0, 6'b100000);
    chk("ito.st", 32'(state), 32'd7);
    chk("ito.trap", 32'(trap), 32'd1);
    chk("ito.cause", 32'(cause), 32'd2);

    // Ack in the 4th wait cycle is accepted
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "iack.Fw", 3'd0, 6'b100000);
    step(1'b1, 1'b0, "iack.F", 3'd0, 6'b110000);
    chk("iack.st", 32'(state), 32'd1);
    chk("iack.trap", 32'(trap), 32'd0);

    // DMEM timeout after 4 MEM cycles
    do_reset();
    op = OP_LOAD;
    step(1'b1, 1'b0, "dto.F", 3'd0, 6'b110000);
    step(1'b0, 1'b0, "dto.D", 3'd1, 6'b000000);
    step(1'b0, 1'b0, "dto.E", 3'd2, 6'b000000);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "dto.M", 3'd3, 6'b001000);
    chk("dto.st", 32'(state), 32'd7);
    chk("dto.cause", 32'(cause), 32'd3);
    chk("dto.instret", 32'(instret), 32'd0);

    // Reset while in MEM with DMEM_REQ high
    do_reset();
    run4(OP_IMM, "pre", 1'b1);
    op = OP_STORE;
    step(1'b1, 1'b0, "rm.F", 3'd0, 6'b110000);
    step(1'b0, 1'b0, "rm.D", 3'd1, 6'b000000);
    step(1'b0, 1'b0, "rm.E", 3'd2, 6'b000000);
    chk("rm.instret0", 32'(instret), 32'd1);
    chk("rm.dreq", 32'(sb), 32'(6'b001100));
    do_reset();
    #1;
    chk("rm.st", 32'(state), 32'd0);
    chk("rm.sb", 32'(sb), 32'(6'b100000));
    chk("rm.instret", 32'(instret), 32'd0);

    // 17 retirements wrap a 4-bit counter to 1
    do_reset();
    for (int i = 0; i < 17; i++) run4(OP_IMM, "wrap", 1'b1);
    chk("wrap.instret", 32'(instret), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer for the RV32I-subset core. It steps each instruction through FETCH, DECODE, EXEC, optional MEM, and WB. It sequences the datapath by generating the write-enable strobes, and it handles the req/ack handshakes with instruction and data memory, including timeouts. It sits beside the combinational instruction decoder, which still supplies the mux and ALU selects; this block only decides *when* state is committed. It also traps illegal opcodes and bus timeouts, and counts retired instructions.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles to wait for IMEM_ACK/DMEM_ACK; 0 disables timeout
- CNT_W, 32: width of INSTRET

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  reset, synchronous, active-high
- OP_CODE  in  7  opcode field from the instruction register; stable from DECODE until return to FETCH
- IMEM_ACK  in  1  instruction memory has valid data this cycle
- DMEM_ACK  in  1  data memory completed read/write this cycle
- IMEM_REQ  out  1  instruction fetch request
- IR_WE  out  1  load instruction register
- DMEM_REQ  out  1  data memory request
- DMEM_WE  out  1  data memory write qualifier (SW)
- RF_WE  out  1  register-file write strobe
- PC_WE  out  1  PC update strobe
- TRAP  out  1  sticky trap flag
- TRAP_CAUSE  out  2  00 none, 01 illegal opcode, 10 IMEM timeout, 11 DMEM timeout
- INSTRET  out  CNT_W  retired-instruction count
- STATE  out  3  current state encoding

## Operation
- States:
  - FETCH=0
  - DECODE=1
  - EXEC=2
  - MEM=3
  - WB=4
  - TRAP=7
  - 5 and 6 are unused and recover to FETCH.
- FETCH:
  - IMEM_REQ=1.
  - If IMEM_ACK, assert IR_WE and go to DECODE.
  - Otherwise wait; on timeout go to TRAP with cause 10.
- DECODE:
  - Classify OP_CODE. Legal opcodes are 0010011, 0000011, 1100111, 0100011, 0110011, 0110111, 1100011, 1101111.
  - Any other opcode goes to TRAP with cause 01.
  - Otherwise go to EXEC.
- EXEC:
  - One cycle.
  - LW (0000011) and SW (0100011) go to MEM; all others go to WB.
- MEM:
  - DMEM_REQ=1 until DMEM_ACK. DMEM_WE=1 for SW only.
  - On ack: LW goes to WB. SW asserts PC_WE, increments INSTRET, and goes to FETCH.
  - On timeout go to TRAP with cause 11.
- WB:
  - PC_WE=1 and INSTRET+1, then go to FETCH.
  - RF_WE=1 for every legal opcode except branch (1100011).
- TRAP:
  - All strobes 0, TRAP=1, TRAP_CAUSE held. Only RST exits.
- Wait timer:
  - Cleared on entry to FETCH/MEM and incremented each waiting cycle without ack.
  - Acks arriving in wait cycles 0..TIMEOUT-1 are accepted.
  - If no ack has arrived after TIMEOUT cycles, the next state is TRAP.
  - Ack in the same cycle as expiry: ack wins.
- INSTRET wraps modulo 2^CNT_W with no flag. It increments exactly when PC_WE=1.

## Timing
- Reset values (cycle after RST sampled high):
  - STATE=FETCH, IMEM_REQ=1, TRAP=0, TRAP_CAUSE=00, INSTRET=0
  - IR_WE, DMEM_REQ, DMEM_WE, RF_WE, PC_WE all 0
- Output timing:
  - IMEM_REQ, DMEM_REQ, DMEM_WE, RF_WE, TRAP and STATE are Moore outputs decoded from state.
  - IR_WE=FETCH&IMEM_ACK.
  - PC_WE=WB | (MEM&SW&DMEM_ACK).
- Latency with zero-wait acks:
  - ALU, LUI, JAL, JALR and branch: 4 cycles (F,D,E,W)
  - LW: 5 cycles
  - SW: 4 cycles
  - Each wait cycle adds 1.
- Strobes (IR_WE, RF_WE, PC_WE) are single-cycle pulses per instruction; none is ever asserted twice per instruction.
- RST mid-operation, e.g. in MEM with DMEM_REQ high: the next cycle is FETCH with no RF_WE/PC_WE pulse, the instruction is not retired, and INSTRET=0.
- RST has priority over every transition, including TRAP.

## Structure
- Shared package riscv_ctrl_pkg holds:
  - opcode constants (OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_REG, OP_LUI, OP_BRANCH, OP_JAL)
  - state encodings
  - TRAP_CAUSE codes
- The decoder's opcode comparisons use the same package constants.
- One sub-module: bus_wait_timer, with clear, tick and expired, parameterized by TIMEOUT. It is instantiated once and shared by FETCH and MEM.

## Test plan
- Reset, then ADDI with zero-wait IMEM_ACK:
  - STATE 0→1→2→4→0
  - IR_WE in cycle 0, RF_WE and PC_WE in cycle 3
  - INSTRET=1
- LW with DMEM_ACK delayed 3 cycles:
  - DMEM_REQ high for 4 cycles, DMEM_WE=0
  - RF_WE one cycle after the ack
  - total 8 cycles
- SW then BNE:
  - SW: DMEM_WE=1 in MEM and PC_WE on the ack cycle, RF_WE never asserted
  - BNE: PC_WE in WB with RF_WE=0
  - INSTRET=2
- OP_CODE=0001111 in DECODE:
  - next cycle STATE=7, TRAP=1, TRAP_CAUSE=01
  - no PC_WE; state holds 10 cycles until RST
- TIMEOUT=4:
  - IMEM_ACK never arrives: TRAP with cause 10 after 4 FETCH cycles
  - repeat with ack in the 4th wait cycle: DECODE entered, no trap
- RST pulsed while in MEM with DMEM_REQ=1:
  - next cycle STATE=0, all strobes 0, INSTRET=0
  - CNT_W=4 run of 17 instructions: INSTRET wraps to 1
